// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared fetch-stage state encoding and instruction constants
package instruction_fetch_pkg;
  typedef enum logic {FETCH, HOLD} fetch_state_t;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_INC = 4;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: fixed-latency instruction fetch with a hold/ready handshake to decode
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int PC_WIDTH = 64
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [PC_WIDTH-1:0]    StartPC,
  output logic [PC_WIDTH-1:0]    Address,
  input  logic [INSTR_WIDTH-1:0] Data,
  output logic [INSTR_WIDTH-1:0] InstrOut,
  output logic [PC_WIDTH-1:0]    PCOut,
  output logic                   InstrValid,
  input  logic                   InstrReady,
  input  logic                   Redirect,
  input  logic [PC_WIDTH-1:0]    RedirectPC
);
  localparam logic [PC_WIDTH-1:0] align_mask = ~PC_WIDTH'(3);
  logic [PC_WIDTH-1:0] pc;
  logic [3:0] cnt;
  fetch_state_t state;
  logic capture;
  assign Address = pc;
  assign capture = (state == FETCH) && (cnt == 4'(RD_LATENCY - 1));
  // Reset beats Redirect, which beats both capture and handshake
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc <= StartPC & align_mask;
      InstrOut <= '0;
      PCOut <= '0;
      InstrValid <= 1'b0;
      cnt <= '0;
      state <= FETCH;
    end else if (Redirect) begin
      pc <= RedirectPC & align_mask;
      InstrValid <= 1'b0;
      cnt <= '0;
      state <= FETCH;
    end else if (capture) begin
      InstrOut <= Data;
      PCOut <= pc;
      InstrValid <= 1'b1;
      cnt <= '0;
      state <= HOLD;
    end else if (state == FETCH) begin
      cnt <= cnt + 4'd1;
    end else if (InstrReady) begin
      pc <= pc + PC_WIDTH'(PC_INC);
      InstrValid <= 1'b0;
      state <= FETCH;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch timing, handshake, redirect and reset
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst;
  logic [63:0] start_pc;
  logic [63:0] address;
  logic [31:0] data;
  logic [31:0] instr_out;
  logic [63:0] pc_out;
  logic instr_valid;
  logic instr_ready;
  logic redirect;
  logic [63:0] redirect_pc;
  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  instruction_fetch #(.RD_LATENCY(2), .PC_WIDTH(64)) dut (
    .CLK(clk),
    .Reset(rst),
    .StartPC(start_pc),
    .Address(address),
    .Data(data),
    .InstrOut(instr_out),
    .PCOut(pc_out),
    .InstrValid(instr_valid),
    .InstrReady(instr_ready),
    .Redirect(redirect),
    .RedirectPC(redirect_pc)
  );

  // instruction memory: one-cycle registered read, shorter than RD_LATENCY
  always_ff @(posedge clk) data <= mem[address[7:2]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!instr_valid && cyc < 20);
    if (!instr_valid) chk("valid_timeout", 64'(instr_valid), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'hF84003E9;
    mem[1] = 32'hF84083EA;
    mem[2] = 32'hF84103EB;
    mem[8] = 32'h8B0901AD;
    mem[13] = 32'hD2E24689;
    rst = 1'b1;
    start_pc = 64'h0;
    instr_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 64'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr_out), 64'd0);
    chk("rst_pcout", pc_out, 64'd0);
    chk("rst_addr", address, 64'd0);
    rst = 1'b0;
    wait_valid(n);
    chk("seq0_lat", 64'(n), 64'd2);
    chk("seq0_instr", 64'(instr_out), 64'hF84003E9);
    chk("seq0_pc", pc_out, 64'h0);
    wait_valid(n);
    chk("seq1_gap", 64'(n), 64'd3);
    chk("seq1_instr", 64'(instr_out), 64'hF84083EA);
    chk("seq1_pc", pc_out, 64'h4);
    wait_valid(n);
    chk("seq2_gap", 64'(n), 64'd3);
    chk("seq2_instr", 64'(instr_out), 64'hF84103EB);
    chk("seq2_pc", pc_out, 64'h8);
    redirect = 1'b1;
    redirect_pc = 64'h1C;
    instr_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid(n);
    chk("hold_pc", pc_out, 64'h1C);
    chk("hold_instr", 64'(instr_out), 64'hA000_0007);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(instr_valid), 64'd1);
      chk("hold_instr_stable", 64'(instr_out), 64'hA000_0007);
      chk("hold_pc_stable", pc_out, 64'h1C);
      chk("hold_addr_stable", address, 64'h1C);
    end
    instr_ready = 1'b1;
    wait_valid(n);
    chk("after_hold_gap", 64'(n), 64'd3);
    chk("after_hold_pc", pc_out, 64'h20);
    chk("after_hold_instr", 64'(instr_out), 64'h8B0901AD);
    redirect = 1'b1;
    redirect_pc = 64'h28;
    instr_ready = 1'b0;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid(n);
    chk("hs_redir_pre_pc", pc_out, 64'h28);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h1E;
    @(negedge clk);
    redirect = 1'b0;
    chk("hs_redir_addr", address, 64'h1C);
    chk("hs_redir_valid", 64'(instr_valid), 64'd0);
    wait_valid(n);
    chk("hs_redir_lat", 64'(n), 64'd2);
    chk("hs_redir_pc", pc_out, 64'h1C);
    @(negedge clk);
    chk("cap_redir_fetch_addr", address, 64'h20);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 64'h8;
    @(negedge clk);
    redirect = 1'b0;
    chk("cap_redir_valid", 64'(instr_valid), 64'd0);
    chk("cap_redir_addr", address, 64'h8);
    wait_valid(n);
    chk("cap_redir_lat", 64'(n), 64'd2);
    chk("cap_redir_pc", pc_out, 64'h8);
    chk("cap_redir_instr", 64'(instr_out), 64'hF84103EB);
    rst = 1'b1;
    start_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    rst = 1'b0;
    chk("wrap_start_addr", address, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_valid(n);
    chk("wrap_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", 64'(instr_out), 64'hA000_003F);
    @(negedge clk);
    chk("wrap_next_addr", address, 64'h0);
    chk("wrap_next_valid", 64'(instr_valid), 64'd0);
    rst = 1'b1;
    start_pc = 64'h14;
    instr_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_valid(n);
    chk("rst_hold_pc", pc_out, 64'h14);
    rst = 1'b1;
    start_pc = 64'h37;
    redirect = 1'b1;
    redirect_pc = 64'h8;
    instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    chk("rst_hold_valid", 64'(instr_valid), 64'd0);
    chk("rst_hold_addr", address, 64'h34);
    chk("rst_hold_instr", 64'(instr_out), 64'd0);
    chk("rst_hold_pcout", pc_out, 64'd0);
    wait_valid(n);
    chk("rst_first_lat", 64'(n), 64'd2);
    chk("rst_first_pc", pc_out, 64'h34);
    chk("rst_first_instr", 64'(instr_out), 64'hD2E24689);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
